// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
   parameter int ADDRESS_BITS = 16
);
   logic                    imem_req_valid;
   logic                    imem_req_ready;
   logic [ADDRESS_BITS-1:0] imem_req_addr;
   logic                    imem_resp_valid;
   logic [31:0]             imem_resp_data;
   logic                    inst_valid;
   logic                    inst_ready;
   logic [ADDRESS_BITS-1:0] PC;
   logic [31:0]             instruction;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, PC, instruction,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, PC, instruction,
      output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential fetches, tags responses with their request PC,
// buffers up to two instructions for decode and handles redirects by dropping stale responses.
module fetch_unit #(
   parameter int                      ADDRESS_BITS = 16,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC     = {ADDRESS_BITS{1'b0}}
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    next_PC_select,
   input  logic [ADDRESS_BITS-1:0] target_PC,
   fetch_unit_if.master            bus
);
   localparam logic [ADDRESS_BITS-1:0] PC_STEP    = ADDRESS_BITS'(4);
   localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

   logic [ADDRESS_BITS-1:0]      fetch_pc_q, fetch_pc_d;
   logic [1:0]                   outstanding_q, outstanding_d;
   logic [1:0]                   drop_q, drop_d;
   logic [1:0]                   count_q, count_d;
   logic                         head_q, head_d;
   logic                         tag_rd_q, tag_rd_d;
   logic [1:0][ADDRESS_BITS-1:0] tag_q, tag_d;
   logic [1:0][ADDRESS_BITS-1:0] buf_pc_q, buf_pc_d;
   logic [1:0][31:0]             buf_inst_q, buf_inst_d;

   logic req_valid_s, accept_s, resp_s, enq_s, deq_s, inst_valid_s;
   logic tag_wr_s, tail_s;

   // Slots are addressed relative to the read/head pointers, so two pointers plus counts suffice.
   assign req_valid_s  = !reset && !next_PC_select &&
                         (({1'b0, outstanding_q} + {1'b0, count_q}) < 3'd2);
   assign accept_s     = req_valid_s && bus.imem_req_ready;
   assign resp_s       = bus.imem_resp_valid;
   assign inst_valid_s = (count_q != 2'd0) && !reset;
   assign deq_s        = inst_valid_s && bus.inst_ready;
   assign enq_s        = resp_s && (drop_q == 2'd0) && !next_PC_select;
   assign tag_wr_s     = tag_rd_q ^ outstanding_q[0];
   assign tail_s       = head_q ^ count_q[0];

   assign bus.imem_req_valid = req_valid_s;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.inst_valid     = inst_valid_s;
   assign bus.PC             = buf_pc_q[head_q];
   assign bus.instruction    = buf_inst_q[head_q];

   // Next-state logic for the fetch pointer, request tag FIFO and instruction buffer.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q + {1'b0, accept_s} - {1'b0, resp_s};
      drop_d        = drop_q;
      count_d       = count_q;
      head_d        = head_q;
      tag_rd_d      = tag_rd_q;
      tag_d         = tag_q;
      buf_pc_d      = buf_pc_q;
      buf_inst_d    = buf_inst_q;

      if (accept_s) begin
         tag_d[tag_wr_s] = fetch_pc_q;
         fetch_pc_d      = fetch_pc_q + PC_STEP;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end

      if (resp_s) begin
         tag_rd_d = ~tag_rd_q;
      end else begin
         tag_rd_d = tag_rd_q;
      end

      if (next_PC_select) begin
         // Every response still in flight belongs to the abandoned path.
         fetch_pc_d = target_PC & ALIGN_MASK;
         drop_d     = outstanding_q - {1'b0, resp_s};
         count_d    = 2'd0;
         head_d     = 1'b0;
      end else begin
         if (resp_s && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
         end else begin
            drop_d = drop_q;
         end
         if (enq_s) begin
            buf_pc_d[tail_s]   = tag_q[tag_rd_q];
            buf_inst_d[tail_s] = bus.imem_resp_data;
         end else begin
            buf_pc_d   = buf_pc_q;
            buf_inst_d = buf_inst_q;
         end
         count_d = count_q + {1'b0, enq_s} - {1'b0, deq_s};
         head_d  = head_q ^ deq_s;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= 2'd0;
         drop_q        <= 2'd0;
         count_q       <= 2'd0;
         head_q        <= 1'b0;
         tag_rd_q      <= 1'b0;
         tag_q         <= '0;
         buf_pc_q      <= '0;
         buf_inst_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
         head_q        <= head_d;
         tag_rd_q      <= tag_rd_d;
         tag_q         <= tag_d;
         buf_pc_q      <= buf_pc_d;
         buf_inst_q    <= buf_inst_d;
      end
   end
endmodule
